pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, exception-code and branch-delay tagging, and a flush input. It is the generic replacement for the fixed per-stage registers between IF/ID/EX/MEM/WB. The payload is opaque, typically {Instr, PC}. It adds backpressure, exception-kills-payload, and a saturating stall counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid buffer,
// exception-kills-payload capture, branch-delay tagging, flush and a stall counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned EXC_W   = 5,
    parameter bit          SKID_EN = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    entry_t in_entry_c;
    logic   main_valid_c;
    logic   skid_valid_c;
    logic   stalled_c;
    logic   in_fire_c;
    logic   out_fire_c;

    assign main_valid_c = (state_q != ST_EMPTY);
    assign skid_valid_c = (state_q == ST_FULL);
    assign stalled_c    = main_valid_c && !out_ready;

    // With the skid buffer in_ready is purely registered; without it, it looks through out_ready.
    assign in_ready   = SKID_EN ? !skid_valid_c : (!main_valid_c || out_ready);
    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = main_valid_c && out_ready;

    // An excepting instruction travels as a bubble that carries only its code and bd flag.
    always_comb begin
        in_entry_c      = '0;
        in_entry_c.data = (in_exc != '0) ? '0 : in_data;
        in_entry_c.exc  = in_exc;
        in_entry_c.bd   = in_bd;
    end

    // Occupancy next-state and entry updates; flush wins over any transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d   = ST_EMPTY;
            main_d    = '0;
            main_d.bd = stalled_c ? main_q.bd : 1'b0;
            skid_d    = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire_c) begin
                        main_d  = in_entry_c;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire_c && out_fire_c) begin
                        main_d = in_entry_c;
                    end else if (in_fire_c) begin
                        skid_d  = in_entry_c;
                        state_d = ST_FULL;
                    end else if (out_fire_c) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire_c) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Consecutive-stall counter, saturating.
    always_comb begin
        stall_d = '0;
        if (!flush && stalled_c) begin
            stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid = main_valid_c;
    assign out_data  = main_q.data;
    assign out_exc   = main_q.exc;
    assign out_bd    = main_q.bd;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one instance without and one with the skid buffer,
// both checked every cycle against a queue-based occupancy model.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [4:0]  in_exc;
    logic        in_bd;
    logic        out_ready;

    logic        ir [2];
    logic        ov [2];
    logic        ob [2];
    logic [63:0] od [2];
    logic [4:0]  oe [2];
    logic [7:0]  sc [2];

    pipe_stage_reg #(.DATA_W(64), .EXC_W(5), .SKID_EN(1'b0), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_exc(oe[0]), .out_bd(ob[0]),
        .stall_cnt(sc[0])
    );

    pipe_stage_reg #(.DATA_W(64), .EXC_W(5), .SKID_EN(1'b1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_exc(oe[1]), .out_bd(ob[1]),
        .stall_cnt(sc[1])
    );

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  e;
        logic        b;
    } ent_t;

    // Reference model: per instance, an ordered list of held entries (capacity 1 or 2).
    ent_t mq [2][2];
    int   mcnt [2];
    int   stall_e [2];
    bit   bd_e [2];
    bit   bdk [2];
    bit   acc [2];

    int total = 0;
    int bad   = 0;

    logic [63:0] seen0 [$];
    logic [63:0] seen1 [$];
    int max_sc1;
    int lowcnt1;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic bit exp_rdy(input int k);
        if (k == 1) return (mcnt[1] < 2);
        return (mcnt[0] == 0) || (out_ready === 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0; stall_e[k] = 0; bd_e[k] = 1'b0; bdk[k] = 1'b1; acc[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin : step
                bit   v, pop, push;
                ent_t c;
                v    = (mcnt[k] > 0);
                pop  = v && out_ready;
                push = in_valid && exp_rdy(k);
                c.d  = (in_exc != 5'd0) ? 64'd0 : in_data;
                c.e  = in_exc;
                c.b  = in_bd;
                if (flush) begin
                    bd_e[k]    = (v && !out_ready) ? mq[k][0].b : 1'b0;
                    bdk[k]     = 1'b1;
                    mcnt[k]    = 0;
                    stall_e[k] = 0;
                    acc[k]     = 1'b0;
                end else begin
                    if (v && !out_ready) stall_e[k] = (stall_e[k] >= 255) ? 255 : stall_e[k] + 1;
                    else                 stall_e[k] = 0;
                    if (pop) begin
                        mq[k][0] = mq[k][1];
                        mcnt[k]  = mcnt[k] - 1;
                    end
                    if (push) begin
                        mq[k][mcnt[k]] = c;
                        mcnt[k]        = mcnt[k] + 1;
                    end
                    if (pop || push) bdk[k] = 1'b0;
                    acc[k] = push;
                end
            end
        end
    end

    // Monitor: compare presented outputs with the model head and log accepted words.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, 64'(ov[k]), 64'(mcnt[k] > 0));
            if (mcnt[k] > 0) begin
                chk("out_data", k, od[k], mq[k][0].d);
                chk("out_exc", k, 64'(oe[k]), 64'(mq[k][0].e));
                chk("out_bd", k, 64'(ob[k]), 64'(mq[k][0].b));
            end else begin
                chk("idle_data", k, od[k], 64'd0);
                chk("idle_exc", k, 64'(oe[k]), 64'd0);
                if (bdk[k]) chk("idle_bd", k, 64'(ob[k]), 64'(bd_e[k]));
            end
            chk("in_ready", k, 64'(ir[k]), 64'(exp_rdy(k)));
            chk("stall_cnt", k, 64'(sc[k]), 64'(stall_e[k]));
        end
        if (rst_n && !flush && out_ready) begin
            if (ov[0]) seen0.push_back(od[0]);
            if (ov[1]) seen1.push_back(od[1]);
        end
        if (int'(sc[1]) > max_sc1) max_sc1 = int'(sc[1]);
        if (ir[1] === 1'b0) lowcnt1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; in_exc = 5'd0; in_bd = 1'b0; in_data = 64'd0;
    endtask

    // Hold each word until the skid instance accepts it; out_ready low in [s0, s0+slen).
    task automatic stream(input logic [63:0] base, input int n, input int s0, input int slen);
        int idx;
        idx = 0;
        for (int c = 0; c < 64 && idx < n; c++) begin
            in_valid  = 1'b1;
            in_data   = base + 64'(idx);
            in_exc    = 5'd0;
            in_bd     = 1'b0;
            out_ready = !(c >= s0 && c < s0 + slen);
            tick();
            if (acc[1]) idx++;
        end
        chk("stream_done", 1, 64'(idx), 64'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic chk_seq(input int k, input logic [63:0] base, input int n);
        int sz;
        sz = (k == 0) ? seen0.size() : seen1.size();
        chk("seq_len", k, 64'(sz), 64'(n));
        for (int i = 0; i < n && i < sz; i++)
            chk("seq_word", k, (k == 0) ? seen0[i] : seen1[i], base + 64'(i));
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        max_sc1 = 0;
        lowcnt1 = 0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 64'(ov[k]), 64'd0);
            chk("rst_data", k, od[k], 64'd0);
            chk("rst_exc", k, 64'(oe[k]), 64'd0);
            chk("rst_bd", k, 64'(ob[k]), 64'd0);
            chk("rst_stall", k, 64'(sc[k]), 64'd0);
            chk("rst_ready", k, 64'(ir[k]), 64'd1);
        end
        rst_n = 1'b1;
        tick();

        seen0.delete(); seen1.delete();
        stream(64'd1, 8, -1, 0);
        chk_seq(0, 64'd1, 8);
        chk_seq(1, 64'd1, 8);

        seen1.delete(); max_sc1 = 0; lowcnt1 = 0;
        stream(64'hA0, 6, 2, 3);
        chk_seq(1, 64'hA0, 6);
        chk("bp_stall_peak", 1, 64'(max_sc1), 64'd3);
        chk("bp_in_ready_low", 1, 64'(lowcnt1 > 0), 64'd1);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0040_3000_1234_5678; in_exc = 5'd4;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            chk("exc_valid", k, 64'(ov[k]), 64'd1);
            chk("exc_data", k, od[k], 64'd0);
            chk("exc_code", k, 64'(oe[k]), 64'd4);
        end
        out_ready = 1'b1;
        repeat (2) tick();

        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11; in_bd = 1'b1;
        tick();
        in_data = 64'h22; in_bd = 1'b0; flush = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            chk("fl_st_valid", k, 64'(ov[k]), 64'd0);
            chk("fl_st_bd", k, 64'(ob[k]), 64'd1);
            chk("fl_st_exc", k, 64'(oe[k]), 64'd0);
            chk("fl_st_stall", k, 64'(sc[k]), 64'd0);
        end
        tick();
        for (int k = 0; k < 2; k++) chk("fl_st_drop", k, 64'(ov[k]), 64'd0);

        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h33; in_bd = 1'b1;
        tick();
        idle_inputs();
        flush = 1'b1;
        for (int k = 0; k < 2; k++) chk("fl_un_pre_bd", k, 64'(ob[k]), 64'd1);
        tick();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("fl_un_valid", k, 64'(ov[k]), 64'd0);
            chk("fl_un_bd", k, 64'(ob[k]), 64'd0);
        end

        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h44;
        tick();
        in_valid = 1'b0;
        repeat (300) tick();
        for (int k = 0; k < 2; k++) chk("stall_sat", k, 64'(sc[k]), 64'd255);
        out_ready = 1'b1;
        repeat (2) tick();

        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, 64'(ov[k]), 64'd0);
            chk("arst_stall", k, 64'(sc[k]), 64'd0);
            chk("arst_data", k, od[k], 64'd0);
            chk("arst_ready", k, 64'(ir[k]), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            chk("rel_valid", k, 64'(ov[k]), 64'd1);
            chk("rel_data", k, od[k], 64'h55);
        end
        tick();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            in_exc    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            in_bd     = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1 chk("comb_ready_a", 0, 64'(ir[0]), 64'((mcnt[0] == 0) || out_ready));
            out_ready = ~out_ready;
            #1 chk("comb_ready_b", 0, 64'(ir[0]), 64'((mcnt[0] == 0) || out_ready));
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
